// File: rtl/div_sched_pkg.sv
// Shared encodings and constants for the divide scheduler and its watchdog.
package div_sched_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } state_e;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic [63:0] ZeroDWord = 64'h0;

endpackage

// File: rtl/div_watchdog.sv
// Busy-cycle counter for the divider; flags the last permitted cycle and keeps
// a sticky record of any operation that had to be abandoned for running long.
module div_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic hold,
  output logic expire,
  output logic timeout
);

  localparam logic [CW-1:0] LastCnt = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign expire = en & (cnt == LastCnt);

  // hold covers a flush or a result landing on the final cycle: neither is a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (en)
        cnt <= cnt + 1'b1;
      if (expire & ~hold)
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/div_sched.sv
// Execute-stage sequencer for the shared divider; owns HI/LO and stalls the
// pipeline from request acceptance until the result is committed or dropped.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_opr1,
  input  logic [31:0] ex_opr2,
  input  logic        flush,
  output logic        stall,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_abandon,
  output logic [31:0] div_opr1,
  output logic [31:0] div_opr2,
  input  logic        div_ready,
  input  logic [63:0] div_res,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_timeout
);

  state_e state;
  logic   is_div, is_mt, req, mt, expire;

  assign is_div = ex_valid & ((ex_op == OP_DIV) | (ex_op == OP_DIVU));
  assign is_mt  = ex_valid & ((ex_op == OP_MTHI) | (ex_op == OP_MTLO));
  assign req    = is_div & ~flush;
  assign mt     = is_mt & ~flush & ~stall;

  // Expiry releases stall so the abandoned instruction leaves EX rather than reissuing.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:    stall = req;
      BUSY:    stall = ~div_ready & ~flush & ~expire;
      DRAIN:   stall = req | (is_mt & ~flush);
      default: stall = 1'b0;
    endcase
    if (rst) stall = 1'b0;
  end

  assign div_abandon = (state == BUSY) & (flush | (expire & ~div_ready));

  div_watchdog #(.TIMEOUT(TIMEOUT), .CW(CW)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state == IDLE) & req),
    .en      (state == BUSY),
    .hold    (flush | div_ready),
    .expire  (expire),
    .timeout (div_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_start  <= 1'b0;
      div_signed <= 1'b0;
      div_opr1   <= ZeroWord;
      div_opr2   <= ZeroWord;
      hi         <= ZeroWord;
      lo         <= ZeroWord;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            div_opr1   <= ex_opr1;
            div_opr2   <= ex_opr2;
            div_signed <= (ex_op == OP_DIV);
            div_start  <= 1'b1;
            state      <= BUSY;
          end else if (mt) begin
            if (ex_op == OP_MTHI) hi <= ex_opr1;
            else                  lo <= ex_opr1;
          end
        end
        BUSY: begin
          if (flush) begin
            div_start <= 1'b0;
            state     <= IDLE;
          end else if (div_ready) begin
            hi        <= div_res[63:32];
            lo        <= div_res[31:0];
            div_start <= 1'b0;
            state     <= DRAIN;
          end else if (expire) begin
            div_start <= 1'b0;
            state     <= IDLE;
          end
        end
        // No new start until the divider has dropped the previous result.
        DRAIN: if (!div_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Execute-stage controller that sequences the shared 32-bit divider for DIV/DIVU and owns the architectural HI/LO registers.
- Accepts one divide request per instruction, drives the divider's start/abandon handshake and stalls the pipeline until the result is committed.
- Handles pipeline flush mid-operation and a divider watchdog.
- Also services MTHI/MTLO writes.

Parameters:
- TIMEOUT, 64, maximum BUSY cycles before the operation is forcibly abandoned.
- CW, 7, width of the busy-cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX-stage instruction valid.
- ex_op  in  3  operation: NOP=0, DIV=1, DIVU=2, MTHI=3, MTLO=4; others treated as NOP.
- ex_opr1  in  32  dividend, or MTHI/MTLO source.
- ex_opr2  in  32  divisor.
- flush  in  1  exception/pipeline flush; kills the in-flight EX instruction.
- stall  out  1  holds EX and upstream stages (combinational).
- div_start  out  1  start to divider; held high for the whole operation.
- div_signed  out  1  1 for DIV, 0 for DIVU.
- div_abandon  out  1  one-cycle cancel pulse to divider.
- div_opr1  out  32  latched dividend.
- div_opr2  out  32  latched divisor.
- div_ready  in  1  divider result valid; level, stays high while start is held.
- div_res  in  64  [63:32] remainder→HI, [31:0] quotient→LO.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- div_timeout  out  1  sticky flag, set on watchdog abandon; cleared only by rst.

Behaviour:
- Reset values: state IDLE; hi, lo, div_opr1, div_opr2, counter = 0; div_start, div_signed, div_abandon, div_timeout = 0. stall = 0 during reset.
- Request definitions:
  - req = ex_valid & (ex_op==DIV | ex_op==DIVU) & !flush.
  - mt = ex_valid & (ex_op==MTHI | ex_op==MTLO) & !flush & !stall.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - On req: latch operands into div_opr1/div_opr2, set div_signed, div_start <= 1, counter <= 0, go to BUSY.
  - stall = req in the same cycle.
  - On mt: at the clock edge, hi or lo <= ex_opr1.
- BUSY:
  - stall = !div_ready & !flush.
  - Counter increments each cycle.
  - If flush: div_abandon = 1 for exactly one cycle, div_start <= 0, go to IDLE; HI/LO unchanged. flush has priority over a same-cycle div_ready.
  - Else if div_ready: hi <= div_res[63:32], lo <= div_res[31:0], div_start <= 0, go to DRAIN. stall deasserts this cycle, so EX advances exactly at the commit edge.
  - Else if counter == TIMEOUT-1: abandon pulse, div_start <= 0, div_timeout <= 1, go to IDLE; HI/LO unchanged, stall released.
- DRAIN:
  - Wait for div_ready == 0, then go to IDLE.
  - stall = req, so a back-to-back divide waits; no new start is issued while ready is still high.
  - mt is not accepted in DRAIN; it stalls like req.
- Divide-by-zero: no special casing. The divider returns 0 with ready, so HI = LO = 0 is committed.
- Reset mid-operation: asynchronous return to IDLE with all reset values. The divider sees rst itself, so no abandon pulse is issued.
- A flush arriving in IDLE or DRAIN does nothing except suppress req/mt.
- Operands are sampled only at the IDLE→BUSY edge; later changes on ex_opr* are ignored.

Decomposition:
- Shared package/defines file holds:
  - op encodings (NOP/DIV/DIVU/MTHI/MTLO);
  - state encodings: IDLE=2'b00, BUSY=2'b01, DRAIN=2'b10;
  - ZeroWord and ZeroDWord constants.
- One natural sub-module: div_watchdog, holding the counter, compare and sticky timeout flag. It is enabled in BUSY and cleared on entry.
- The HI/LO register file stays inline.

Test Plan:
- DIVU 100/7, divider model ready after 10 cycles:
  - stall high for 10 cycles;
  - commit HI=0x00000002, LO=0x0000000E;
  - div_start falls at the commit edge;
  - back to IDLE one cycle after ready falls.
- DIV 0xFFFFFFF9 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; div_signed=1 throughout BUSY.
- DIV 5/0, model returns ready with res=0 after 2 cycles → HI=LO=0; no timeout.
- DIVU 1000/3, flush raised on cycle 4 of BUSY:
  - exactly one div_abandon pulse;
  - HI/LO keep their prior values (preloaded via MTHI 0xAAAA5555, MTLO 0x1234);
  - stall low the next cycle.
- Two back-to-back DIVU (10/3 then 9/2):
  - second request stalls through DRAIN;
  - final HI=1, LO=4;
  - exactly two rising edges on div_start.
- Divider model never asserts ready:
  - abandon after exactly 64 BUSY cycles;
  - div_timeout=1 and stays set until rst;
  - assert rst mid-BUSY in a repeat run → all outputs return to reset values asynchronously.
